// File: rtl/wb_dbg_pkg.sv
// Shared constants and types for the UART-to-Wishbone debug master.
package wb_dbg_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  localparam logic [7:0] CMD_RD    = 8'h52;
  localparam logic [7:0] CMD_WR    = 8'h57;
  localparam logic [7:0] RSP_RD_OK = 8'h72;
  localparam logic [7:0] RSP_WR_OK = 8'h77;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] RSP_TMO   = 8'h54;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_RESP_HDR,
    ST_RESP_DATA
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_RD) || (b == CMD_WR);
  endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone bus bundle with master/slave views.
interface wb_if;
  logic [wb_dbg_pkg::WB_ADR_W-1:0] adr;
  logic [wb_dbg_pkg::WB_DAT_W-1:0] dat_m;
  logic [wb_dbg_pkg::WB_DAT_W-1:0] dat_s;
  logic                            we;
  logic [wb_dbg_pkg::WB_SEL_W-1:0] sel;
  logic                            cyc;
  logic                            stb;
  logic                            ack;
  logic                            err;
  logic                            stall;

  modport master (
    output adr, dat_m, we, sel, cyc, stb,
    input  dat_s, ack, err, stall
  );

  modport slave (
    input  adr, dat_m, we, sel, cyc, stb,
    output dat_s, ack, err, stall
  );
endinterface

// File: rtl/wb_uart_dbg_master.sv
// UART byte-stream debug master: 'R'/'W' frames become single Wishbone cycles.
// Optional bus timeout enabled by macro WB_DBG_TIMEOUT_EN.
module wb_uart_dbg_master
  import wb_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_stb,
  output logic [7:0] o_tx_data,
  output logic       o_tx_stb,
  input  logic       i_tx_busy,
  wb_if.master       wb,
  output logic       o_overrun
);

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_cnt, w_cnt_d;
  logic                  r_we, w_we_d;
  logic [WB_ADR_W-1:0]   r_adr, w_adr_d;
  logic [WB_DAT_W-1:0]   r_dat_m, w_dat_m_d;
  logic [WB_DAT_W-1:0]   r_rdata, w_rdata_d;
  logic                  r_cyc, w_cyc_d;
  logic                  r_stb, w_stb_d;
  logic                  r_tx_stb, w_tx_stb_d;
  logic [7:0]            r_tx_data, w_tx_data_d;
  logic                  r_overrun, w_overrun_d;

  logic w_on_bus;
  logic w_timeout;
  logic w_done;
  logic w_tx_acc;
  logic w_last;

  assign w_on_bus = (r_state == ST_BUS_REQ) || (r_state == ST_BUS_WAIT);
  assign w_done   = w_on_bus && (wb.ack || wb.err || w_timeout);
  assign w_tx_acc = r_tx_stb && !i_tx_busy;
  assign w_last   = i_rx_stb && (r_cnt == 2'd3);

`ifdef WB_DBG_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo;

  // Zero whenever off the bus, so every bus cycle starts counting from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_tmo <= '0;
    else if (!w_on_bus) r_tmo <= '0;
    else               r_tmo <= r_tmo + 16'd1;
  end

  assign w_timeout = w_on_bus && (r_tmo == TMO_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (i_rx_stb && is_cmd(i_rx_data)) w_state_nxt = ST_ADDR;
      ST_ADDR:      if (w_last) w_state_nxt = r_we ? ST_DATA : ST_BUS_REQ;
      ST_DATA:      if (w_last) w_state_nxt = ST_BUS_REQ;
      ST_BUS_REQ: begin
        if (w_done)         w_state_nxt = ST_RESP_HDR;
        else if (!wb.stall) w_state_nxt = ST_BUS_WAIT;
      end
      ST_BUS_WAIT:  if (w_done) w_state_nxt = ST_RESP_HDR;
      ST_RESP_HDR: begin
        if (w_tx_acc) w_state_nxt = (r_tx_data == RSP_RD_OK) ? ST_RESP_DATA : ST_IDLE;
      end
      ST_RESP_DATA: if (w_tx_acc && (r_cnt == 2'd3)) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_d     = r_cnt;
    w_we_d      = r_we;
    w_adr_d     = r_adr;
    w_dat_m_d   = r_dat_m;
    w_rdata_d   = r_rdata;
    w_cyc_d     = r_cyc;
    w_stb_d     = r_stb;
    w_tx_stb_d  = r_tx_stb;
    w_tx_data_d = r_tx_data;
    w_overrun_d = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_stb && is_cmd(i_rx_data)) begin
          w_we_d  = (i_rx_data == CMD_WR);
          w_cnt_d = 2'd0;
        end
      end
      ST_ADDR: begin
        if (i_rx_stb) begin
          w_adr_d = {i_rx_data, r_adr[WB_ADR_W-1:8]};
          w_cnt_d = 2'(r_cnt + 2'd1);
        end
        if (w_last && !r_we) begin
          w_cyc_d = 1'b1;
          w_stb_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (i_rx_stb) begin
          w_dat_m_d = {i_rx_data, r_dat_m[WB_DAT_W-1:8]};
          w_cnt_d   = 2'(r_cnt + 2'd1);
        end
        if (w_last) begin
          w_cyc_d = 1'b1;
          w_stb_d = 1'b1;
        end
      end
      ST_BUS_REQ, ST_BUS_WAIT: begin
        w_overrun_d = i_rx_stb;
        if (w_done) begin
          // err outranks a simultaneous ack; timeout only when neither arrived
          w_cyc_d    = 1'b0;
          w_stb_d    = 1'b0;
          w_tx_stb_d = 1'b1;
          if (wb.err) begin
            w_tx_data_d = RSP_ERR;
          end else if (wb.ack) begin
            if (r_we) begin
              w_tx_data_d = RSP_WR_OK;
            end else begin
              w_tx_data_d = RSP_RD_OK;
              w_rdata_d   = wb.dat_s;
            end
          end else begin
            w_tx_data_d = RSP_TMO;
          end
        end else if ((r_state == ST_BUS_REQ) && !wb.stall) begin
          w_stb_d = 1'b0;
        end
      end
      ST_RESP_HDR: begin
        w_overrun_d = i_rx_stb;
        if (w_tx_acc) begin
          if (r_tx_data == RSP_RD_OK) begin
            w_tx_data_d = r_rdata[7:0];
            w_rdata_d   = {8'h00, r_rdata[WB_DAT_W-1:8]};
            w_cnt_d     = 2'd0;
          end else begin
            w_tx_stb_d = 1'b0;
          end
        end
      end
      ST_RESP_DATA: begin
        w_overrun_d = i_rx_stb;
        if (w_tx_acc) begin
          if (r_cnt == 2'd3) begin
            w_tx_stb_d = 1'b0;
          end else begin
            w_tx_data_d = r_rdata[7:0];
            w_rdata_d   = {8'h00, r_rdata[WB_DAT_W-1:8]};
            w_cnt_d     = 2'(r_cnt + 2'd1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat_m   <= '0;
      r_rdata   <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_tx_stb  <= 1'b0;
      r_tx_data <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_d;
      r_we      <= w_we_d;
      r_adr     <= w_adr_d;
      r_dat_m   <= w_dat_m_d;
      r_rdata   <= w_rdata_d;
      r_cyc     <= w_cyc_d;
      r_stb     <= w_stb_d;
      r_tx_stb  <= w_tx_stb_d;
      r_tx_data <= w_tx_data_d;
      r_overrun <= w_overrun_d;
    end
  end

  assign wb.adr    = r_adr;
  assign wb.dat_m  = r_dat_m;
  assign wb.we     = r_we;
  assign wb.sel    = {WB_SEL_W{1'b1}};
  assign wb.cyc    = r_cyc;
  assign wb.stb    = r_stb;
  assign o_tx_data = r_tx_data;
  assign o_tx_stb  = r_tx_stb;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_wb_uart_dbg_master.sv
// Randomized bench for wb_uart_dbg_master against a transaction-level model.
module tb_wb_uart_dbg_master;

  localparam int unsigned TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_busy;
  logic       overrun;

  wb_if wb_bus();

  wb_uart_dbg_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rx_data (rx_data),
    .i_rx_stb  (rx_stb),
    .o_tx_data (tx_data),
    .o_tx_stb  (tx_stb),
    .i_tx_busy (tx_busy),
    .wb        (wb_bus),
    .o_overrun (overrun)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [31:0] exp_adr = '0;
  logic [31:0] exp_dat = '0;
  bit          exp_we  = 1'b0;
  int          exp_stb = 1;
  int          exp_cyc = -1;
  bit          busy_window = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Transmitter randomly busy so the hold-until-accepted rule is exercised.
  always begin
    @(negedge clk);
    tx_busy = ($urandom_range(0, 2) == 0);
  end

  // Per-cycle compare against the expected transaction and response stream.
  bit         p_cyc = 0, p_stb = 0, p_hold = 0, exp_ovr = 0;
  logic [7:0] p_data = '0;
  int         cyc_cnt = 0, stb_cnt = 0;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      p_cyc = 0; p_stb = 0; p_hold = 0; exp_ovr = 0; cyc_cnt = 0; stb_cnt = 0;
    end else begin
      chk("overrun", {31'h0, overrun}, {31'h0, exp_ovr});
      exp_ovr = rx_stb && busy_window;
      if (p_hold) chk("tx_hold", {23'h0, tx_stb, tx_data}, {23'h0, 1'b1, p_data});
      if (tx_stb && !tx_busy) begin
        if (exp_tx.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected actual=%h required=none t=%0t", tx_data, $time);
        end else begin
          chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
        end
        tx_log.push_back(tx_data);
      end
      p_hold = tx_stb && tx_busy;
      p_data = tx_data;
      if (wb_bus.stb) begin
        stb_cnt++;
        chk("stb_needs_cyc", {31'h0, wb_bus.cyc}, 32'h1);
        chk("wb_adr", wb_bus.adr, exp_adr);
        chk("wb_we", {31'h0, wb_bus.we}, {31'h0, exp_we});
        chk("wb_sel", {28'h0, wb_bus.sel}, 32'hF);
        if (exp_we) chk("wb_dat_m", wb_bus.dat_m, exp_dat);
      end
      if (p_stb && !wb_bus.stb) begin
        chk("stb_cycles", stb_cnt, exp_stb);
        stb_cnt = 0;
      end
      if (wb_bus.cyc) cyc_cnt++;
      else if (p_cyc) begin
        if (exp_cyc >= 0) chk("cyc_cycles", cyc_cnt, exp_cyc);
        cyc_cnt = 0;
      end
      p_cyc = wb_bus.cyc;
      p_stb = wb_bus.stb;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // mode 0: ack/err response, 1: no response (timeout), 2: reset while waiting
  task automatic run_txn(input int mode, input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, input int nstall, input int lat,
                         input bit do_err, input bit both, input logic [31:0] rdata,
                         input bit inj, input int nnoise);
    logic [7:0] frame[9];
    logic [7:0] b;
    int nb, n;
    @(negedge clk);
    for (int i = 0; i < nnoise; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'h52 || b == 8'h57);
      send_byte(b, 1);
    end
    exp_adr = adr; exp_dat = dat; exp_we = we; exp_stb = nstall + 1;
    exp_cyc = (mode == 0) ? nstall + lat + 1 : (mode == 1) ? int'(TMO) : -1;
    if (mode == 1)      exp_tx.push_back(8'h54);
    else if (mode == 2) ;
    else if (do_err)    exp_tx.push_back(8'h45);
    else if (we)        exp_tx.push_back(8'h77);
    else begin
      exp_tx.push_back(8'h72);
      for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
    end
    frame[0] = we ? 8'h57 : 8'h52;
    for (int i = 0; i < 4; i++) frame[1+i] = adr[8*i +: 8];
    for (int i = 0; i < 4; i++) frame[5+i] = dat[8*i +: 8];
    nb = we ? 9 : 5;
    for (int i = 0; i < nb; i++) send_byte(frame[i], (i == nb - 1) ? 0 : $urandom_range(0, 2));
    busy_window = 1'b1;
    chk("bus_latency", {30'h0, wb_bus.cyc, wb_bus.stb}, 32'h3);
    wb_bus.stall = (nstall > 0);
    repeat (nstall) @(negedge clk);
    wb_bus.stall = 1'b0;
    if (mode == 1) begin
      n = 0;
      while (wb_bus.cyc && n < int'(TMO) + 4) begin @(negedge clk); n++; end
      chk("timeout_cyc_low", {31'h0, wb_bus.cyc}, 32'h0);
    end else if (mode == 2) begin
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cyc_async", {31'h0, wb_bus.cyc}, 32'h0);
      chk("rst_stb_async", {31'h0, wb_bus.stb}, 32'h0);
      chk("rst_tx_stb", {31'h0, tx_stb}, 32'h0);
      busy_window = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        rx_stb  = inj && (k == 0);
        rx_data = 8'($urandom_range(0, 255));
      end
      wb_bus.ack   = !do_err || both;
      wb_bus.err   = do_err;
      wb_bus.dat_s = rdata;
      @(negedge clk);
      rx_stb       = 1'b0;
      wb_bus.ack   = 1'b0;
      wb_bus.err   = 1'b0;
      wb_bus.dat_s = $urandom;
      chk("cyc_drop_after_resp", {31'h0, wb_bus.cyc}, 32'h0);
    end
    n = 0;
    while (exp_tx.size() > 0 && n < 200) begin @(negedge clk); n++; end
    chk("resp_drained", exp_tx.size(), 0);
    repeat (2) @(negedge clk);
    busy_window = 1'b0;
  endtask

  task automatic chk_log(input string name, input logic [7:0] lit[], input int len);
    chk({name, "_len"}, tx_log.size(), len);
    for (int i = 0; i < len && i < tx_log.size(); i++)
      chk(name, {24'h0, tx_log[i]}, {24'h0, lit[i]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit_w[]  = '{8'h77};
    logic [7:0] lit_r[]  = '{8'h72, 8'h78, 8'h56, 8'h34, 8'h12};
    logic [7:0] lit_e[]  = '{8'h45};
    logic [7:0] lit_t[]  = '{8'h54};
    bit we, er, inj;
    int mode, lat;
    rst_n = 1'b0; rx_stb = 1'b0; rx_data = '0; tx_busy = 1'b0;
    wb_bus.ack = 1'b0; wb_bus.err = 1'b0; wb_bus.stall = 1'b0; wb_bus.dat_s = '0;
    #3;
    chk("rst_cyc", {31'h0, wb_bus.cyc}, 32'h0);
    chk("rst_stb", {31'h0, wb_bus.stb}, 32'h0);
    chk("rst_we", {31'h0, wb_bus.we}, 32'h0);
    chk("rst_tx_stb", {31'h0, tx_stb}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_adr", wb_bus.adr, 32'h0);
    chk("rst_dat_m", wb_bus.dat_m, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    tx_log.delete();
    run_txn(0, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    chk_log("write_resp", lit_w, 1);

    tx_log.delete();
    run_txn(0, 1'b0, 32'h1000_0004, 32'h0, 3, 0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 0);
    chk_log("read_resp", lit_r, 5);

    tx_log.delete();
    run_txn(0, 1'b0, 32'h0000_0100, 32'h0, 0, 1, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 0);
    chk_log("err_resp", lit_e, 1);

    tx_log.delete();
    run_txn(0, 1'b0, 32'h0000_0200, 32'h0, 1, 0, 1'b1, 1'b1, 32'h5555_AAAA, 1'b0, 0);
    chk_log("err_wins", lit_e, 1);

    @(negedge clk);
    send_byte(8'hAA, 2);
    tx_log.delete();
    run_txn(0, 1'b0, 32'h0000_0300, 32'h0, 0, 3, 1'b0, 1'b0, 32'h0BAD_CAFE, 1'b1, 1);
    chk("noise_ovr_resp_len", tx_log.size(), 5);

`ifdef WB_DBG_TIMEOUT_EN
    tx_log.delete();
    run_txn(1, 1'b0, 32'h0000_0400, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    chk_log("timeout_resp", lit_t, 1);
`endif

    tx_log.delete();
    run_txn(2, 1'b0, 32'h0000_0500, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    chk("rst_no_resp", tx_log.size(), 0);
    run_txn(0, 1'b0, 32'h0000_0600, 32'h0, 1, 1, 1'b0, 1'b0, 32'h8765_4321, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      we   = $urandom_range(0, 1) == 1;
      er   = $urandom_range(0, 5) == 0;
      lat  = $urandom_range(0, 3);
      inj  = (lat >= 1) && ($urandom_range(0, 2) == 0);
      mode = 0;
`ifdef WB_DBG_TIMEOUT_EN
      if ($urandom_range(0, 9) == 0) mode = 1;
`endif
      run_txn(mode, we, $urandom, $urandom, $urandom_range(0, 3), lat, er,
              $urandom_range(0, 1) == 1, $urandom, inj && (mode == 0), $urandom_range(0, 2));
    end

    chk("final_queue_empty", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_uart_dbg_master.md
WB_UART_DBG_MASTER -- requirements
Module: wb_uart_dbg_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: bus cycles to wait for ack/err before abort; valid range 1..65535.
REQ-002 i_clk  input  1  single clock; all logic on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_rx_data  input  8  received UART byte.
REQ-005 i_rx_stb  input  1  one-cycle strobe qualifying i_rx_data; no backpressure.
REQ-006 o_tx_data  output  8  byte to transmit.
REQ-007 o_tx_stb  output  1  transmit request, held until accepted.
REQ-008 i_tx_busy  input  1  transmitter busy; byte accepted on the first cycle with o_tx_stb=1 and i_tx_busy=0.
REQ-009 wb  wb_if.master  --  pipelined Wishbone master: adr 32, dat_m 32, dat_s 32, we, sel 4, cyc, stb, ack, err, stall.
REQ-010 o_overrun  output  1  one-cycle pulse when a received byte is dropped.

Function
REQ-011 Frames: cmd 0x52 'R' + 4 address bytes; cmd 0x57 'W' + 4 address bytes + 4 data bytes; multi-byte fields LSB first.
REQ-012 Other bytes in IDLE are discarded silently (no overrun pulse).
REQ-013 FSM states: IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP_HDR, RESP_DATA.
REQ-014 IDLE->ADDR on valid cmd; ADDR->DATA (write) or ->BUS_REQ (read) after 4th address byte; DATA->BUS_REQ after 4th data byte.
REQ-015 BUS_REQ: cyc=stb=1, sel=4'b1111, we per cmd; stb drops on the first cycle with stall=0; cyc held; go to BUS_WAIT.
REQ-016 Ack/err sampled in BUS_REQ as well as BUS_WAIT; ack or err in the stall=0 cycle completes the transfer directly.
REQ-017 On ack or err: cyc=stb=0 next cycle; dat_s captured on ack of a read; go to RESP_HDR.
REQ-018 Response header: read ok 0x72 'r', write ok 0x77 'w', err 0x45 'E', timeout 0x54 'T'.
REQ-019 RESP_DATA follows only 'r': 4 read-data bytes, LSB first; otherwise RESP_HDR->IDLE.
REQ-020 Bus latency: first stb no later than 1 cycle after the last frame byte strobe.
REQ-021 Bytes strobed in BUS_REQ, BUS_WAIT, RESP_HDR or RESP_DATA are dropped with o_overrun pulse.
REQ-022 ack and err in the same cycle: err wins.
REQ-023 Address/data shift registers update only on i_rx_stb in ADDR/DATA.

Reset
REQ-024 Async assert forces IDLE; cyc, stb, we, o_tx_stb, o_overrun = 0; adr, dat_m, o_tx_data, counters = 0.
REQ-025 Reset mid-bus-cycle drops cyc immediately; no response byte is sent.
REQ-026 Deassertion is synchronized externally; the block needs no internal reset synchronizer.

Configuration
REQ-027 Macro WB_DBG_TIMEOUT_EN defined: a 16-bit counter clears on entry to BUS_REQ and counts every cycle in BUS_REQ/BUS_WAIT; reaching TIMEOUT_CYCLES drops cyc/stb and responds 'T'.
REQ-028 Macro undefined: no counter; the master waits indefinitely for ack/err and TIMEOUT_CYCLES is unused.

Structure
REQ-029 Package wb_dbg_pkg holds the command/response byte constants and the FSM state enum typedef.
REQ-030 Single module, no sub-modules; the 32-bit LSB-first byte shifter is inline.

Verification
REQ-031 Write: 57 10 00 00 20 EF BE AD DE -> one cycle adr=0x20000010, dat_m=0xDEADBEEF, we=1; ack -> tx 0x77.
REQ-032 Read: 52 04 00 00 10, slave stalls 3 cycles then acks 0x12345678 -> stb held 4 cycles; tx 72 78 56 34 12.
REQ-033 Err: read with err=1 -> tx 0x45 only; cyc low the next cycle.
REQ-034 Timeout (WB_DBG_TIMEOUT_EN, TIMEOUT_CYCLES=8), no ack -> cyc low after 8 cycles; tx 0x54.
REQ-035 Noise/overrun: 0xAA in IDLE ignored; byte during BUS_WAIT -> o_overrun pulse, response unaffected.
REQ-036 i_rst_n low during BUS_WAIT -> cyc=0 asynchronously; following read frame completes normally.
